// File: rtl/ttc_pkg.sv
// Shared types and defaults for the truth-table checker.
package ttc_pkg;

    localparam int TTC_N_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } ttc_state_e;

endpackage

// File: rtl/tt_eval.sv
// Combinational minterm lookup: f is the mask bit selected by vec.
module tt_eval
#(
    parameter  int N = 3,
    localparam int M = 2 ** N
)
(
    input  logic [M-1:0] mask,
    input  logic [N-1:0] vec,
    output logic         f
);

    assign f = mask[vec];

endmodule

// File: rtl/truth_table_checker.sv
// Truth-table checker: sweeps all 2**N input combinations and compares a
// reference minterm mask against a candidate mask row by row.
// Optional macro TTC_STEP_EN adds a 'step' input that gates row advance.
module truth_table_checker
    import ttc_pkg::*;
#(
    parameter  int N = TTC_N_DEFAULT,
    localparam int M = 2 ** N
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef TTC_STEP_EN
    input  logic         step,
`endif
    input  logic [M-1:0] mask_a,
    input  logic [M-1:0] mask_b,
    output logic [N-1:0] vec,
    output logic         fa,
    output logic         fb,
    output logic         valid,
    output logic         mismatch,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_bad,
    output logic         busy,
    output logic         done,
    output logic         equal
);

    localparam logic [N-1:0] VEC_LAST = '1;

    ttc_state_e   state_q, state_d;
    logic [N-1:0] vec_q, vec_d;
    logic [N-1:0] first_bad_q, first_bad_d;
    logic [M-1:0] mask_a_q, mask_a_d;
    logic [M-1:0] mask_b_q, mask_b_d;
    logic [N:0]   err_q, err_d;
    logic         equal_q, equal_d;
    logic         adv;
    logic         row_bad;

`ifdef TTC_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    tt_eval #(.N(N)) u_eval_a (.mask(mask_a_q), .vec(vec_q), .f(fa));
    tt_eval #(.N(N)) u_eval_b (.mask(mask_b_q), .vec(vec_q), .f(fb));

    assign row_bad   = fa ^ fb;
    assign valid     = (state_q == SWEEP);
    assign busy      = (state_q == SWEEP);
    assign done      = (state_q == DONE);
    assign mismatch  = valid & row_bad;
    assign vec       = vec_q;
    assign err_count = err_q;
    assign first_bad = first_bad_q;
    assign equal     = equal_q;

    // Next-state and datapath update for the IDLE -> SWEEP -> DONE sweep.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        first_bad_d = first_bad_q;
        mask_a_d    = mask_a_q;
        mask_b_d    = mask_b_q;
        err_d       = err_q;
        equal_d     = equal_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_a_d    = mask_a;
                    mask_b_d    = mask_b;
                    err_d       = '0;
                    first_bad_d = '0;
                    equal_d     = 1'b0;
                    vec_d       = '0;
                    state_d     = SWEEP;
                end
            end
            SWEEP: begin
                if (adv) begin
                    if (row_bad) begin
                        err_d = err_q + (N+1)'(1);
                        if (err_q == '0) begin
                            first_bad_d = vec_q;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        // equal is settled here so it is already valid in DONE
                        equal_d = (err_d == '0);
                        vec_d   = '0;
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + N'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            first_bad_q <= '0;
            mask_a_q    <= '0;
            mask_b_q    <= '0;
            err_q       <= '0;
            equal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            first_bad_q <= first_bad_d;
            mask_a_q    <= mask_a_d;
            mask_b_q    <= mask_b_d;
            err_q       <= err_d;
            equal_q     <= equal_d;
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker (N=3 and N=1 instances).
module tb_truth_table_checker;

    logic       clk = 1'b0;
    logic       rst, start, start1;
    logic [7:0] ma, mb;
    logic [1:0] ma1, mb1;
`ifdef TTC_STEP_EN
    logic       step;
`endif

    logic [2:0] vec, fbad;
    logic [3:0] err;
    logic       fa, fb, valid, mism, busy, done, equal;
    logic [0:0] vec1, fbad1;
    logic [1:0] err1;
    logic       fa1, fb1, valid1, mism1, busy1, done1, equal1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    truth_table_checker #(.N(3)) u_dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef TTC_STEP_EN
        .step(step),
`endif
        .mask_a(ma), .mask_b(mb), .vec(vec), .fa(fa), .fb(fb),
        .valid(valid), .mismatch(mism), .err_count(err), .first_bad(fbad),
        .busy(busy), .done(done), .equal(equal)
    );

    truth_table_checker #(.N(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
`ifdef TTC_STEP_EN
        .step(step),
`endif
        .mask_a(ma1), .mask_b(mb1), .vec(vec1), .fa(fa1), .fb(fb1),
        .valid(valid1), .mismatch(mism1), .err_count(err1), .first_bad(fbad1),
        .busy(busy1), .done(done1), .equal(equal1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         exp_err;
        int         exp_first;
        logic       exp_eq;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: count differing minterms and find the lowest one.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output int errs, output int first);
        errs  = 0;
        first = 0;
        for (int i = 0; i < 8; i++) begin
            if (a[i] != b[i]) begin
                if (errs == 0) first = i;
                errs++;
            end
        end
    endfunction

    // One full sweep with per-row and end-of-sweep checks; noisy perturbs inputs.
    task automatic run_sweep(input logic [7:0] a, input logic [7:0] b, input bit noisy);
        int e, f, run;
        model(a, b, e, f);
        run = 0;
        @(negedge clk);
        ma = a; mb = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk("valid", valid, 1);
            chk("busy", busy, 1);
            chk("done_row", done, 0);
            chk("vec", vec, i);
            chk("fa", fa, a[i]);
            chk("fb", fb, b[i]);
            chk("mismatch", mism, a[i] ^ b[i]);
            chk("err_running", err, run);
            chk("equal_row", equal, 0);
            if (a[i] != b[i]) run++;
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                ma    = 8'($urandom);
                mb    = 8'($urandom);
            end
        end
        @(negedge clk);
        chk("done", done, 1);
        chk("valid_done", valid, 0);
        chk("busy_done", busy, 0);
        chk("err_final", err, e);
        chk("first_bad", fbad, f);
        chk("equal", equal, (e == 0));
        start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", valid, 0);
        chk("hold_err", err, e);
        chk("hold_first", fbad, f);
        chk("hold_equal", equal, (e == 0));
    endtask

    initial begin
        tbl[0] = '{8'b1000_1010, 8'b1000_1010, 0, 0, 1'b1};
        tbl[1] = '{8'b1000_1010, 8'b1000_1000, 1, 1, 1'b0};
        tbl[2] = '{8'hFF,        8'h00,        8, 0, 1'b0};
        tbl[3] = '{8'hF0,        8'h0F,        8, 0, 1'b0};
        tbl[4] = '{8'h80,        8'h00,        1, 7, 1'b0};
        tbl[5] = '{8'h0C,        8'h04,        1, 3, 1'b0};
        tbl[6] = '{8'h3C,        8'h18,        2, 2, 1'b0};

        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        ma = '0; mb = '0; ma1 = '0; mb1 = '0;
`ifdef TTC_STEP_EN
        step = 1'b1;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_vec", vec, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_first", fbad, 0);
        chk("rst_equal", equal, 0);
        chk("rst_busy1", busy1, 0);

        // Directed table.
        for (int t = 0; t < 7; t++) begin
            run_sweep(tbl[t].a, tbl[t].b, 1'b0);
            chk("tbl_err", err, tbl[t].exp_err);
            chk("tbl_first", fbad, tbl[t].exp_first);
            chk("tbl_equal", equal, tbl[t].exp_eq);
        end

        // Held results survive several idle cycles.
        repeat (3) @(negedge clk);
        chk("idle_hold_err", err, 2);
        chk("idle_hold_first", fbad, 2);

        // Randomised sweeps with input noise during the sweep.
        for (int k = 0; k < 20; k++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            run_sweep(ra, rb, 1'b1);
        end

        // Reset mid-sweep at vec=4; captured masks must clear too.
        @(negedge clk);
        ma = 8'hFF; mb = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_vec", vec, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_vec", vec, 0);
        chk("mid_rst_fa", fa, 0);
        chk("mid_rst_fb", fb, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_mism", mism, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_first", fbad, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_equal", equal, 0);
        @(negedge clk);
        chk("post_rst_idle", busy, 0);

        // Reset wins over start.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_over_start", busy, 0);

        // N=1 instance: two rows, both mismatching.
        ma1 = 2'b10; mb1 = 2'b01; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("n1_valid0", valid1, 1);
        chk("n1_vec0", vec1, 0);
        chk("n1_fa0", fa1, 0);
        chk("n1_fb0", fb1, 1);
        chk("n1_mism0", mism1, 1);
        @(negedge clk);
        chk("n1_valid1", valid1, 1);
        chk("n1_vec1", vec1, 1);
        chk("n1_fa1", fa1, 1);
        chk("n1_fb1", fb1, 0);
        @(negedge clk);
        chk("n1_done", done1, 1);
        chk("n1_valid_done", valid1, 0);
        chk("n1_err", err1, 2);
        chk("n1_first", fbad1, 0);
        chk("n1_equal", equal1, 0);

`ifdef TTC_STEP_EN
        // Stepped sweep: advance only on every third cycle.
        begin
            int r, run;
            bit fin;
            r = 0; run = 0; fin = 1'b0;
            @(negedge clk);
            ma = 8'b1000_1010; mb = 8'b1000_1000; start = 1'b1; step = 1'b0;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 40 && !fin; c++) begin
                if (c > 0) @(negedge clk);
                if (r == 8) begin
                    chk("step_done", done, 1);
                    chk("step_err", err, 1);
                    chk("step_first", fbad, 1);
                    fin = 1'b1;
                end else begin
                    chk("step_valid", valid, 1);
                    chk("step_vec", vec, r);
                    chk("step_err_running", err, run);
                    step = ((c % 3) == 2);
                    if (step) begin
                        if (ma[r] != mb[r]) run++;
                        r++;
                    end
                end
            end
            if (!fin) chk("step_timeout", 0, 1);
            step = 1'b1;
        end
`endif

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter N, default 3, number of boolean input variables (legal 1..8).
REQ-002 Parameter M = 2**N (localparam, not overridable), number of minterms.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a full truth-table sweep.
REQ-006 mask_a  input  M  reference function as minterm mask; bit i = f(i).
REQ-007 mask_b  input  M  candidate (simplified) function as minterm mask.
REQ-008 vec  output  N  current input combination {x_(N-1)..x_0}.
REQ-009 fa, fb  output  1 each  mask_a / mask_b value at vec.
REQ-010 valid  output  1  vec/fa/fb are a live sweep row this cycle.
REQ-011 mismatch  output  1  valid & (fa != fb).
REQ-012 err_count  output  N+1  number of mismatching rows in current/last sweep.
REQ-013 first_bad  output  N  lowest vec that mismatched; 0 if none.
REQ-014 busy, done, equal  output  1 each  sweeping; sweep-complete pulse; zero mismatches.

Function
REQ-015 FSM states IDLE, SWEEP, DONE; reset and power-up state is IDLE.
REQ-016 IDLE: start=1 captures mask_a/mask_b into internal registers, clears err_count, first_bad, equal; next state SWEEP with vec=0.
REQ-017 Masks are used only from the captured copies; input changes during SWEEP have no effect.
REQ-018 SWEEP: valid=1, busy=1; one row per cycle; vec increments by 1 each advance.
REQ-019 fa/fb are combinational lookups of the captured masks at vec (zero extra latency).
REQ-020 Each valid row with fa!=fb increments err_count and, if first mismatch of the sweep, loads first_bad=vec.
REQ-021 Row vec=M-1 is the last; the advance after it goes to DONE, vec wraps to 0; no extra row is emitted.
REQ-022 First row appears the cycle after start accepted; sweep occupies exactly M valid cycles (free-running mode).
REQ-023 DONE lasts exactly one cycle: done=1, busy=0, valid=0, equal=(err_count==0); then IDLE.
REQ-024 err_count, first_bad, equal hold their values in IDLE until the next accepted start.
REQ-025 start is ignored in SWEEP and DONE; no queueing.
REQ-026 err_count never overflows: maximum M fits in N+1 bits.

Reset
REQ-027 rst=1 at any clock edge, including mid-sweep, forces IDLE, vec=0, err_count=0, first_bad=0, equal=0, valid=busy=done=0; rst takes priority over start.
REQ-028 Captured mask registers are cleared to 0 on reset.

Configuration
REQ-029 Macro TTC_STEP_EN: when defined, adds input port step (1 bit); in SWEEP the row advances only on cycles with step=1, and row counting/err_count update only on the advancing edge; valid stays 1 while waiting.
REQ-030 Without TTC_STEP_EN: no step port; sweep advances every cycle per REQ-022.

Structure
REQ-031 Package ttc_pkg holds the FSM state enum (IDLE, SWEEP, DONE) and default N constant.
REQ-032 Sub-module tt_eval (combinational): parameter N, inputs mask (M) and vec (N), output f; instantiated twice for fa and fb.

Verification
REQ-033 N=3, mask_a=mask_b=8'b1000_1010, start pulse -> 8 valid rows vec 0..7, fa=fb each row, done pulse after row 7, err_count=0, equal=1.
REQ-034 N=3, mask_a=8'b1000_1010, mask_b=8'b1000_1000 -> mismatch only at vec=1, err_count=1, first_bad=1, equal=0.
REQ-035 N=3, mask_a=8'hFF, mask_b=8'h00 -> mismatch every row, err_count=8 (4'b1000), first_bad=0.
REQ-036 rst asserted at vec=4 during sweep -> next cycle IDLE, all outputs 0; start asserted during SWEEP -> ignored, sweep length unchanged.
REQ-037 N=1, mask_a=2'b10, mask_b=2'b01 -> 2 rows, err_count=2, done after 2 valid cycles.
REQ-038 TTC_STEP_EN defined, N=3, step pulsed every 3rd cycle -> vec advances only on step, 8 rows total, err_count as in REQ-034 stimulus.
